sub_ahead_pipe: RTL

SUB_AHEAD_PIPE -- requirements
Module: sub_ahead_pipe

---
 rtl/sub_ahead_pipe_pkg.sv | 18 +
 rtl/sub_ahead_pipe_sub8_lookahead.sv | 34 +++
 rtl/sub_ahead_pipe.sv | 89 ++++++++
 3 files changed

// File: rtl/sub_ahead_pipe_pkg.sv
// Shared constants and the stage-1 register record for the two-stage
// borrow-lookahead subtractor.
package sub_ahead_pipe_pkg;

  localparam int BYTE  = 8;
  localparam int WIDTH = 2 * BYTE;

  // Everything stage 2 needs to finish the high byte and the overflow flag.
  typedef struct packed {
    logic [BYTE-1:0] d_lo;
    logic            b_lo;
    logic [BYTE-1:0] a_hi;
    logic [BYTE-1:0] b_hi;
    logic            a_msb;
    logic            b_msb;
  } s1_rec_t;

endpackage

// File: rtl/sub_ahead_pipe_sub8_lookahead.sv
// Combinational 8-bit subtractor built from per-bit borrow generate and
// propagate terms; one copy serves each pipeline stage.
module sub8_lookahead
  import sub_ahead_pipe_pkg::*;
(
  input  logic [BYTE-1:0] a,
  input  logic [BYTE-1:0] b,
  input  logic            bin,
  output logic [BYTE-1:0] d,
  output logic            bo
);

  logic [BYTE-1:0] g;
  logic [BYTE-1:0] p;
  logic [BYTE-1:0] bw;
  logic            chain;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Borrow into each bit position; bw[i] is the borrow consumed by bit i.
  always_comb begin
    chain = bin;
    bw    = '0;
    for (int i = 0; i < BYTE; i++) begin
      bw[i] = chain;
      chain = g[i] | (p[i] & chain);
    end
  end

  assign d  = a ^ b ^ bw;
  assign bo = chain;

endmodule

// File: rtl/sub_ahead_pipe.sv
// Two-stage valid/ready subtractor: the low byte and its borrow are resolved
// in stage 1, the high byte, borrow-out and signed overflow in stage 2.
module sub_ahead_pipe
  import sub_ahead_pipe_pkg::*;
#(
  parameter int WIDTH = sub_ahead_pipe_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  logic            s1_valid;
  logic            s1_advance;
  logic            s1_load;
  s1_rec_t         s1;
  logic [BYTE-1:0] lo_d;
  logic            lo_bo;
  logic [BYTE-1:0] hi_d;
  logic            hi_bo;

  sub8_lookahead u_lo (
    .a   (a[BYTE-1:0]),
    .b   (b[BYTE-1:0]),
    .bin (bin),
    .d   (lo_d),
    .bo  (lo_bo)
  );

  sub8_lookahead u_hi (
    .a   (s1.a_hi),
    .b   (s1.b_hi),
    .bin (s1.b_lo),
    .d   (hi_d),
    .bo  (hi_bo)
  );

  // Stage 1 may move on whenever the output register is empty or draining.
  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign s1_load    = in_valid && in_ready;

  // Stage 1: low-byte result plus the high-byte operands held for stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_load) begin
        s1.d_lo  <= lo_d;
        s1.b_lo  <= lo_bo;
        s1.a_hi  <= a[WIDTH-1:BYTE];
        s1.b_hi  <= b[WIDTH-1:BYTE];
        s1.a_msb <= a[WIDTH-1];
        s1.b_msb <= b[WIDTH-1];
      end
    end
  end

  // Stage 2: output register; holds its contents while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        diff <= {hi_d, s1.d_lo};
        bout <= hi_bo;
        ovf  <= (s1.a_msb != s1.b_msb) && (hi_d[BYTE-1] != s1.a_msb);
      end
    end
  end

endmodule
